// File: rtl/if_fetch_if.sv
// Bundle for the fetch stage's pipeline-control, instruction-memory and IF/ID signals.
// The master side is the fetch stage; the slave side is its environment.
interface if_fetch_if;
  logic [15:0] npc;
  logic        redirect;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] pc;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;

  modport master (
    input  npc, redirect, stall, flush, imem_ack, imem_data,
    output imem_req, imem_addr, pc, if_instr, if_pc, if_valid
  );

  modport slave (
    output npc, redirect, stall, flush, imem_ack, imem_data,
    input  imem_req, imem_addr, pc, if_instr, if_pc, if_valid
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads to instruction memory
// and loads the IF/ID register, honouring stall, flush and delayed branch redirects.
module if_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input logic         clk,
  input logic         rst,
  if_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [15:0] pc_q, pc_n;
  logic [15:0] if_instr_q, if_instr_n;
  logic [15:0] if_pc_q, if_pc_n;
  logic        if_valid_q, if_valid_n;
  logic        pend_q, pend_n;
  logic [15:0] pend_tgt_q, pend_tgt_n;
  logic [15:0] skid_instr_q, skid_instr_n;
  logic [15:0] skid_pc_q, skid_pc_n;
  logic [15:0] pc_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
      if_valid_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_tgt_q   <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_n;
      pc_q         <= pc_n;
      if_instr_q   <= if_instr_n;
      if_pc_q      <= if_pc_n;
      if_valid_q   <= if_valid_n;
      pend_q       <= pend_n;
      pend_tgt_q   <= pend_tgt_n;
      skid_instr_q <= skid_instr_n;
      skid_pc_q    <= skid_pc_n;
    end
  end

  // PC taken when a fetch completes: a live redirect beats a stored one.
  always_comb begin
    if (bus.redirect)  pc_adv = bus.npc;
    else if (pend_q)   pc_adv = pend_tgt_q;
    else               pc_adv = pc_q + 16'd1;
  end

  always_comb begin
    state_n      = state_q;
    pc_n         = pc_q;
    if_instr_n   = if_instr_q;
    if_pc_n      = if_pc_q;
    if_valid_n   = if_valid_q;
    pend_n       = pend_q;
    pend_tgt_n   = pend_tgt_q;
    skid_instr_n = skid_instr_q;
    skid_pc_n    = skid_pc_q;

    if (bus.flush) begin
      if_instr_n   = NOP_INSTR;
      if_valid_n   = 1'b0;
      pend_n       = 1'b0;
      skid_instr_n = NOP_INSTR;
      skid_pc_n    = '0;
      if (bus.redirect) pc_n = bus.npc;
      state_n      = REQ;
    end else begin
      unique case (state_q)
        IDLE: state_n = REQ;

        REQ: begin
          if (bus.imem_ack) begin
            pc_n   = pc_adv;
            pend_n = 1'b0;
            if (!bus.stall) begin
              if_instr_n = bus.imem_data;
              if_pc_n    = pc_q;
              if_valid_n = 1'b1;
            end else begin
              skid_instr_n = bus.imem_data;
              skid_pc_n    = pc_q;
              state_n      = HELD;
            end
          end else begin
            if (bus.redirect) begin
              pend_n     = 1'b1;
              pend_tgt_n = bus.npc;
            end
            if (!bus.stall) begin
              if_instr_n = NOP_INSTR;
              if_valid_n = 1'b0;
            end
          end
        end

        HELD: begin
          if (bus.redirect) pc_n = bus.npc;
          if (!bus.stall) begin
            if_instr_n = skid_instr_q;
            if_pc_n    = skid_pc_q;
            if_valid_n = 1'b1;
            state_n    = REQ;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.imem_req  = (state_q == REQ);
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_valid  = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic, each cycle compared
// against a queue-based model of the fetch stage.
module tb_if_fetch;
  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  logic rst;
  if_fetch_if bus();

  if_fetch #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rand_data = 1'b0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  // Model: skid contents as a queue (non-empty means the stage is held),
  // stored redirect target as a 0/1-entry queue, plus a post-reset settle cycle.
  logic [15:0] m_pc = '0, m_instr = NOP, m_ifpc = '0;
  logic        m_valid = 1'b0;
  bit          m_settle = 1'b1;
  ent_t        skq[$];
  logic [15:0] tgq[$];

  function automatic logic m_req();
    return !m_settle && (skq.size() == 0);
  endfunction

  task automatic model(input bit r, a, s, rd, f, input logic [15:0] n, d);
    logic [15:0] nxt;
    ent_t e;
    if (r) begin
      m_pc = '0; m_instr = NOP; m_ifpc = '0; m_valid = 1'b0;
      m_settle = 1'b1; skq.delete(); tgq.delete();
    end else if (f) begin
      m_instr = NOP; m_valid = 1'b0;
      skq.delete(); tgq.delete();
      if (rd) m_pc = n;
      m_settle = 1'b0;
    end else if (m_settle) begin
      m_settle = 1'b0;
    end else if (skq.size() != 0) begin
      if (rd) m_pc = n;
      if (!s) begin
        e = skq.pop_front();
        m_instr = e.instr; m_ifpc = e.pc; m_valid = 1'b1;
      end
    end else if (a) begin
      if (rd)                   nxt = n;
      else if (tgq.size() != 0) nxt = tgq[0];
      else                      nxt = m_pc + 16'd1;
      tgq.delete();
      if (!s) begin
        m_instr = d; m_ifpc = m_pc; m_valid = 1'b1;
      end else begin
        e.instr = d; e.pc = m_pc;
        skq.push_back(e);
      end
      m_pc = nxt;
    end else begin
      if (rd) begin
        tgq.delete();
        tgq.push_back(n);
      end
      if (!s) begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, a, s, rd, f, input logic [15:0] n);
    logic [15:0] d;
    d = rand_data ? 16'($urandom) : 16'h4801 + bus.imem_addr;
    rst = r; bus.imem_ack = a; bus.stall = s; bus.redirect = rd;
    bus.flush = f; bus.npc = n; bus.imem_data = d;
    @(posedge clk);
    model(r, a, s, rd, f, n, d);
    #1;
    chk("imem_req",  {15'd0, bus.imem_req}, {15'd0, m_req()});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("pc",        bus.pc,        m_pc);
    chk("if_instr",  bus.if_instr,  m_instr);
    chk("if_pc",     bus.if_pc,     m_ifpc);
    chk("if_valid",  {15'd0, bus.if_valid}, {15'd0, m_valid});
  endtask

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_instr", bus.if_instr, NOP);
    chk("rst_req", {15'd0, bus.imem_req}, 16'd0);

    // zero-wait streaming
    step(0, 1, 0, 0, 0, 16'h0);
    chk("idle_valid", {15'd0, bus.if_valid}, 16'd0);
    repeat (5) step(0, 1, 0, 0, 0, 16'h0);
    chk("stream_ifpc", bus.if_pc, 16'h0004);
    chk("stream_instr", bus.if_instr, 16'h4805);
    chk("stream_pc", bus.pc, 16'h0005);

    // stall coinciding with completion at pc 5
    step(0, 1, 1, 0, 0, 16'h0);
    chk("held_ifpc", bus.if_pc, 16'h0004);
    chk("held_req", {15'd0, bus.imem_req}, 16'd0);
    chk("held_pc", bus.pc, 16'h0006);
    step(0, 1, 1, 0, 0, 16'h0);
    step(0, 1, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 0, 16'h0);
    chk("release_ifpc", bus.if_pc, 16'h0005);
    chk("release_instr", bus.if_instr, 16'h4806);
    chk("release_req", {15'd0, bus.imem_req}, 16'd1);

    // wait states: ack every other cycle
    step(0, 0, 0, 0, 0, 16'h0);
    chk("bubble_instr", bus.if_instr, NOP);
    step(0, 1, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 0, 16'h0);
    chk("ws_pc", bus.pc, 16'h0008);
    step(0, 1, 0, 0, 0, 16'h0);

    // redirect while fetch at pc 9 waits
    step(0, 0, 0, 1, 0, 16'h0040);
    step(0, 0, 0, 0, 0, 16'h0);
    chk("wait_addr", bus.imem_addr, 16'h0009);
    step(0, 1, 0, 0, 0, 16'h0);
    chk("slot_ifpc", bus.if_pc, 16'h0009);
    chk("redir_addr", bus.imem_addr, 16'h0040);

    // flush with redirect during an ack
    step(0, 1, 0, 1, 1, 16'h0100);
    chk("flush_valid", {15'd0, bus.if_valid}, 16'd0);
    chk("flush_addr", bus.imem_addr, 16'h0100);

    // PC wrap
    step(0, 0, 0, 1, 1, 16'hFFFF);
    step(0, 1, 0, 0, 0, 16'h0);
    chk("wrap_ifpc", bus.if_pc, 16'hFFFF);
    chk("wrap_addr", bus.imem_addr, 16'h0000);

    // reset mid-wait, then a late ack while idle
    step(0, 0, 0, 0, 0, 16'h0);
    step(1, 1, 0, 0, 0, 16'h0);
    chk("midrst_valid", {15'd0, bus.if_valid}, 16'd0);
    chk("midrst_req", {15'd0, bus.imem_req}, 16'd0);
    step(0, 1, 0, 0, 0, 16'h0);
    chk("lateack_pc", bus.pc, 16'h0000);
    step(0, 1, 0, 0, 0, 16'h0);

    // random traffic
    rand_data = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) == 0),
           ($urandom_range(1) == 1),
           ($urandom_range(3) == 0),
           ($urandom_range(9) == 0),
           ($urandom_range(19) == 0),
           16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 16-bit pipeline. It owns the architectural PC register and issues request/acknowledge reads to instruction memory. It loads the IF/ID pipeline register and honours stall, flush and branch-redirect requests from downstream. Its Pc output feeds the PC mux, and the selected next PC returns on Npc with Redirect.

## Interface
Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- NOP_INSTR, 16'h0800: encoding written to IF/ID on reset, flush or bubble.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Npc  in  16  redirect target from the PC mux.
- Redirect  in  1  take Npc after the current (delay-slot) fetch completes.
- Stall  in  1  hold the IF/ID register; decode cannot accept.
- Flush  in  1  kill the IF/ID contents and the fetch in flight.
- ImemReq  out  1  read request to instruction memory.
- ImemAddr  out  16  read address; always equals Pc.
- ImemAck  in  1  read data valid this cycle; may be high in the same cycle as the first request cycle.
- ImemData  in  16  instruction word, valid when ImemAck=1.
- Pc  out  16  current fetch PC.
- IfInstr  out  16  IF/ID instruction.
- IfPc  out  16  PC of IfInstr.
- IfValid  out  1  IF/ID holds a real instruction.

## Operation
- States: IDLE, REQ, HELD.
- Reset values: Pc=RESET_PC, IfInstr=NOP_INSTR, IfPc=0, IfValid=0, ImemReq=0, state IDLE, pending-redirect flag clear, skid buffer empty.
- Reset mid-request abandons the request at once. A late ImemAck is ignored while in IDLE.
- IDLE: one cycle, then REQ.
- REQ: ImemReq=1. A "completion" is ImemAck=1 in REQ.
- Completion with Stall=0:
  - IfInstr<=ImemData, IfPc<=Pc, IfValid<=1.
  - Pc advances.
  - State stays REQ.
- Completion with Stall=1:
  - ImemData and Pc go into the skid buffer.
  - Pc advances; state goes to HELD.
  - IF/ID is unchanged.
- No completion with Stall=0: IfInstr<=NOP_INSTR, IfValid<=0 (bubble).
- No completion with Stall=1: IF/ID is held.
- Pc advance rule, in priority order:
  - Redirect=1 this cycle: Pc<=Npc.
  - Pending flag set: Pc<=stored target; clear the flag.
  - Otherwise: Pc<=Pc+1, 16-bit wrap (16'hFFFF -> 16'h0000).
- Redirect in REQ without completion: store Npc, set the pending flag; Pc is unchanged. A later Redirect before completion overwrites the stored target.
- HELD:
  - ImemReq=0.
  - Redirect in HELD loads Pc<=Npc immediately; the buffered word is the delay slot.
  - When Stall=0: IF/ID<=buffer, IfValid<=1, state goes to REQ.
- Flush (priority over Stall and completion):
  - IfInstr<=NOP_INSTR, IfValid<=0.
  - Any ImemAck this cycle is discarded.
  - Skid buffer and pending flag are cleared.
  - Pc<=Npc if Redirect=1, else Pc is unchanged (refetch).
  - State goes to REQ.
- Outside Flush and Rst, Pc never changes while a request is outstanding without ImemAck.

## Timing
- Zero-wait memory (ImemAck tied high in REQ): one instruction per cycle. IfInstr is valid the edge after ImemAddr is presented.
- ImemAddr is combinational from Pc. ImemReq is decoded from state only, with no combinational path from ImemAck.
- Stall-release from HELD costs no bubble: the buffer enters IF/ID on the release edge. The next request issues the cycle after release.
- Redirect latency: the target address appears on ImemAddr the cycle after the delay-slot fetch completes.

## Test plan
- Reset, ImemAck=1, ImemData=16'h4801+addr: ImemAddr runs 0,1,2,… one per cycle; IfInstr/IfPc follow one cycle later; IfValid=1 from the second cycle after Rst falls.
- Two-cycle wait states (ack every other REQ cycle): IfValid alternates 1/0 with IfInstr=16'h0800 on bubbles; Pc advances only on ack cycles.
- Stall=1 for 3 cycles coinciding with a completion at Pc=5:
  - IF/ID holds the old word while stalled.
  - On release, IfPc=5 with its data.
  - Pc=6; no request is issued while in HELD.
- Redirect with Npc=16'h0040 while the fetch at Pc=9 waits 2 cycles:
  - IfPc=9 (delay slot) is delivered.
  - The next ImemAddr is 16'h0040, not 16'h000A.
- Flush with Redirect, Npc=16'h0100, in a cycle with ImemAck=1:
  - That word is discarded; IfValid=0.
  - The next ImemAddr is 16'h0100.
- Pc=16'hFFFF completes: the next ImemAddr is 16'h0000. Also assert Rst mid-wait: all outputs return to their reset values on the next edge.
